// File: rtl/mem_arbiter.sv
// Memory arbiter: three single-entry request slots (I-read, D-read, D-write) are
// served one at a time against a fixed-latency memory, with priority D-write > D-read > I-read.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

module mem_arbiter #(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int LINE_SIZE   = `CACHE_LINE_SIZE,
  parameter int MEM_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_res,
  output logic [LINE_SIZE-1:0] i_res_data,
  output logic [WORD_SIZE-1:0] i_res_addr,
  input  logic                 d_read,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic                 d_wenable,
  input  logic [LINE_SIZE-1:0] d_w_data,
  input  logic [WORD_SIZE-1:0] d_w_addr,
  output logic                 d_res,
  output logic [LINE_SIZE-1:0] d_res_data,
  output logic [WORD_SIZE-1:0] d_res_addr,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic [LINE_SIZE-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic [1:0] {SRV_I, SRV_DR, SRV_DW} srv_e;

  state_e                 state_q, state_d;
  srv_e                   srv_q, srv_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pi_v_q, pi_v_d, pdr_v_q, pdr_v_d, pdw_v_q, pdw_v_d;
  logic [WORD_SIZE-1:0]   pi_addr_q, pi_addr_d, pdr_addr_q, pdr_addr_d, pdw_addr_q, pdw_addr_d;
  logic [LINE_SIZE-1:0]   pdw_data_q, pdw_data_d;
  logic                   mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
  logic                   i_res_q, i_res_d, d_res_q, d_res_d;
  logic [LINE_SIZE-1:0]   i_res_data_q, i_res_data_d, d_res_data_q, d_res_data_d;
  logic [WORD_SIZE-1:0]   i_res_addr_q, i_res_addr_d, d_res_addr_q, d_res_addr_d;
  logic                   svc_i, svc_dr, svc_dw;

  always_comb begin
    state_d      = state_q;
    srv_d        = srv_q;
    cnt_d        = cnt_q;
    pi_v_d       = pi_v_q;
    pi_addr_d    = pi_addr_q;
    pdr_v_d      = pdr_v_q;
    pdr_addr_d   = pdr_addr_q;
    pdw_v_d      = pdw_v_q;
    pdw_addr_d   = pdw_addr_q;
    pdw_data_d   = pdw_data_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_res_d      = 1'b0;
    i_res_data_d = i_res_data_q;
    i_res_addr_d = i_res_addr_q;
    d_res_d      = 1'b0;
    d_res_data_d = d_res_data_q;
    d_res_addr_d = d_res_addr_q;

    svc_i  = (state_q == BUSY) && (srv_q == SRV_I);
    svc_dr = (state_q == BUSY) && (srv_q == SRV_DR);
    svc_dw = (state_q == BUSY) && (srv_q == SRV_DW);

    unique case (state_q)
      IDLE: begin
        if (pdw_v_q || pdr_v_q || pi_v_q) begin
          state_d  = BUSY;
          cnt_d    = CW'(MEM_LATENCY);
          mem_en_d = 1'b1;
          if (pdw_v_q) begin
            srv_d       = SRV_DW;
            pdw_v_d     = 1'b0;
            mem_we_d    = 1'b1;
            mem_addr_d  = pdw_addr_q;
            mem_wdata_d = pdw_data_q;
          end else if (pdr_v_q) begin
            srv_d       = SRV_DR;
            pdr_v_d     = 1'b0;
            mem_addr_d  = pdr_addr_q;
            mem_wdata_d = '0;
          end else begin
            srv_d       = SRV_I;
            pi_v_d      = 1'b0;
            mem_addr_d  = pi_addr_q;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          if (srv_q == SRV_I) begin
            i_res_d      = 1'b1;
            i_res_data_d = mem_rdata;
            i_res_addr_d = mem_addr_q;
          end else if (srv_q == SRV_DR) begin
            d_res_d      = 1'b1;
            d_res_data_d = mem_rdata;
            d_res_addr_d = mem_addr_q;
          end
        end else begin
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot granted this cycle is still valid in _q, so its capture is blocked.
    if (i_read && !pi_v_q && !svc_i) begin
      pi_v_d    = 1'b1;
      pi_addr_d = i_addr;
    end
    if (d_read && !pdr_v_q && !svc_dr) begin
      pdr_v_d    = 1'b1;
      pdr_addr_d = d_addr;
    end
    if (d_wenable && !pdw_v_q && !svc_dw) begin
      pdw_v_d    = 1'b1;
      pdw_addr_d = d_w_addr;
      pdw_data_d = d_w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      srv_q        <= SRV_I;
      cnt_q        <= '0;
      pi_v_q       <= 1'b0;
      pi_addr_q    <= '0;
      pdr_v_q      <= 1'b0;
      pdr_addr_q   <= '0;
      pdw_v_q      <= 1'b0;
      pdw_addr_q   <= '0;
      pdw_data_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_res_q      <= 1'b0;
      i_res_data_q <= '0;
      i_res_addr_q <= '0;
      d_res_q      <= 1'b0;
      d_res_data_q <= '0;
      d_res_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      srv_q        <= srv_d;
      cnt_q        <= cnt_d;
      pi_v_q       <= pi_v_d;
      pi_addr_q    <= pi_addr_d;
      pdr_v_q      <= pdr_v_d;
      pdr_addr_q   <= pdr_addr_d;
      pdw_v_q      <= pdw_v_d;
      pdw_addr_q   <= pdw_addr_d;
      pdw_data_q   <= pdw_data_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_res_q      <= i_res_d;
      i_res_data_q <= i_res_data_d;
      i_res_addr_q <= i_res_addr_d;
      d_res_q      <= d_res_d;
      d_res_data_q <= d_res_data_d;
      d_res_addr_q <= d_res_addr_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign i_res      = i_res_q;
  assign i_res_data = i_res_data_q;
  assign i_res_addr = i_res_addr_q;
  assign d_res      = d_res_q;
  assign d_res_data = d_res_data_q;
  assign d_res_addr = d_res_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked against a
// timeline-based reference model of the slots and the single memory port.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int LS = 128;
  localparam int L  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_wenable;
  logic [W-1:0]  i_addr, d_addr, d_w_addr;
  logic [LS-1:0] d_w_data, mem_rdata;
  logic          i_res, d_res, mem_en, mem_we;
  logic [LS-1:0] i_res_data, d_res_data, mem_wdata;
  logic [W-1:0]  i_res_addr, d_res_addr, mem_addr;

  logic          b_rst, b_i_read, b_i_res, b_d_res, b_mem_en, b_mem_we;
  logic [W-1:0]  b_i_addr, b_i_res_addr, b_d_res_addr, b_mem_addr;
  logic [LS-1:0] b_i_res_data, b_d_res_data, b_mem_wdata, b_mem_rdata;
  logic          b_zero1 = 1'b0;
  logic [W-1:0]  b_zw = '0;
  logic [LS-1:0] b_zl = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .LINE_SIZE(LS), .MEM_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_res(i_res), .i_res_data(i_res_data), .i_res_addr(i_res_addr),
    .d_read(d_read), .d_addr(d_addr), .d_wenable(d_wenable), .d_w_data(d_w_data), .d_w_addr(d_w_addr),
    .d_res(d_res), .d_res_data(d_res_data), .d_res_addr(d_res_addr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WORD_SIZE(W), .LINE_SIZE(LS), .MEM_LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst(b_rst),
    .i_read(b_i_read), .i_addr(b_i_addr), .i_res(b_i_res), .i_res_data(b_i_res_data), .i_res_addr(b_i_res_addr),
    .d_read(b_zero1), .d_addr(b_zw), .d_wenable(b_zero1), .d_w_data(b_zl), .d_w_addr(b_zw),
    .d_res(b_d_res), .d_res_data(b_d_res_data), .d_res_addr(b_d_res_addr),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: slot 0 = I-read, 1 = D-read, 2 = D-write.
  bit            mv[3];
  logic [W-1:0]  ma[3];
  logic [LS-1:0] mwd;
  bit            job;
  int            jslot, jstart;
  logic [W-1:0]  jaddr;
  logic [LS-1:0] jdata, jrd;
  int            cyc = 0;
  bit            fixed_rd = 1'b0;
  int            last_ires = -1, last_dres = -1, n_ires = 0, n_dres = 0;

  task automatic model_reset();
    for (int s = 0; s < 3; s++) mv[s] = 1'b0;
    job = 1'b0;
  endtask

  // Called at posedge+1 of cycle cyc: check outputs, drive inputs, advance model.
  task automatic step(input bit ir, input logic [W-1:0] ia, input bit dr, input logic [W-1:0] da,
                      input bit dw, input logic [W-1:0] dwa, input logic [LS-1:0] dwd);
    bit e_en, e_we, e_ir, e_dr, free, pv[3];
    int g;
    e_en = job && cyc >= jstart && cyc < jstart + L;
    e_we = e_en && jslot == 2;
    e_ir = job && cyc == jstart + L && jslot == 0;
    e_dr = job && cyc == jstart + L && jslot == 1;
    check("mem_en", LS'(mem_en), LS'(e_en));
    check("mem_we", LS'(mem_we), LS'(e_we));
    check("i_res", LS'(i_res), LS'(e_ir));
    check("d_res", LS'(d_res), LS'(e_dr));
    if (e_en) check("mem_addr", LS'(mem_addr), LS'(jaddr));
    if (e_we) check("mem_wdata", mem_wdata, jdata);
    if (e_ir) begin
      check("i_res_data", i_res_data, jrd);
      check("i_res_addr", LS'(i_res_addr), LS'(jaddr));
    end
    if (e_dr) begin
      check("d_res_data", d_res_data, jrd);
      check("d_res_addr", LS'(d_res_addr), LS'(jaddr));
    end
    if (i_res) begin last_ires = cyc; n_ires++; end
    if (d_res) begin last_dres = cyc; n_dres++; end

    i_read = ir; i_addr = ia; d_read = dr; d_addr = da;
    d_wenable = dw; d_w_addr = dwa; d_w_data = dwd;
    mem_rdata = fixed_rd ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
    if (e_en && cyc == jstart + L - 1) jrd = mem_rdata;

    free = !job;
    if (job && cyc == jstart + L) job = 1'b0;
    for (int s = 0; s < 3; s++) pv[s] = mv[s];
    if (ir && !pv[0] && !(e_en && jslot == 0)) begin mv[0] = 1'b1; ma[0] = ia; end
    if (dr && !pv[1] && !(e_en && jslot == 1)) begin mv[1] = 1'b1; ma[1] = da; end
    if (dw && !pv[2] && !(e_en && jslot == 2)) begin mv[2] = 1'b1; ma[2] = dwa; mwd = dwd; end
    if (free && (pv[0] || pv[1] || pv[2])) begin
      g = pv[2] ? 2 : (pv[1] ? 1 : 0);
      job = 1'b1; jslot = g; jaddr = ma[g]; jdata = (g == 2) ? mwd : '0;
      jstart = cyc + 1; mv[g] = 1'b0;
    end
    cyc++;
  endtask

  task automatic tick(input bit ir, input logic [W-1:0] ia, input bit dr, input logic [W-1:0] da,
                      input bit dw, input logic [W-1:0] dwa, input logic [LS-1:0] dwd);
    @(posedge clk);
    #1;
    step(ir, ia, dr, da, dw, dwa, dwd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, '0, 0, '0, 0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, LS'(mem_en), '0);
    check({tag, "_we"}, LS'(mem_we), '0);
    check({tag, "_addr"}, LS'(mem_addr), '0);
    check({tag, "_wdata"}, mem_wdata, '0);
    check({tag, "_ires"}, LS'({i_res, d_res}), '0);
    check({tag, "_rdata"}, i_res_data | d_res_data, '0);
    check({tag, "_raddr"}, LS'(i_res_addr | d_res_addr), '0);
  endtask

  int t0, n0, en_cnt, en_first, b_ires_k;

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    i_read = 0; d_read = 0; d_wenable = 0; i_addr = '0; d_addr = '0; d_w_addr = '0;
    d_w_data = '0; mem_rdata = '0; b_i_read = 0; b_i_addr = '0; b_mem_rdata = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0; b_rst = 1'b0;

    // Single I-read with fixed memory data.
    fixed_rd = 1'b1;
    t0 = cyc;
    tick(1, 32'h1000, 0, '0, 0, '0, '0);
    idle(9);
    check("ires_latency", LS'(last_ires - t0), LS'(7));
    check("ires_line_a5", i_res_data, {16{8'hA5}});
    fixed_rd = 1'b0;

    // All three requests at once: write, then D-read, then I-read.
    t0 = cyc;
    tick(1, 32'h4000, 1, 32'h3000, 1, 32'h2000, {4{32'hDEADBEEF}});
    idle(24);
    check("dres_after_write", LS'(last_dres - t0), LS'(14));
    check("ires_after_dres", LS'(last_ires - t0), LS'(21));

    // Duplicate I-read ignored; new one accepted during response cycle.
    n0 = n_ires;
    t0 = cyc;
    tick(1, 32'h1000, 0, '0, 0, '0, '0);
    idle(2);
    tick(1, 32'h5000, 0, '0, 0, '0, '0);
    idle(3);
    tick(1, 32'h6000, 0, '0, 0, '0, '0);
    check("dup_first_resp", LS'(last_ires - t0), LS'(7));
    idle(10);
    check("dup_second_resp", LS'(last_ires - t0), LS'(14));
    check("dup_resp_count", LS'(n_ires - n0), LS'(2));

    // Reset in the middle of a D-read.
    n0 = n_dres;
    tick(0, '0, 1, 32'h3000, 0, '0, '0);
    idle(4);
    check("pre_rst_busy", LS'(mem_en), LS'(1));
    #2;
    rst = 1'b1;
    i_read = 1; d_read = 1; d_wenable = 1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("held_rst");
    i_read = 0; d_read = 0; d_wenable = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    t0 = cyc;
    tick(0, '0, 1, 32'h7000, 0, '0, '0);
    idle(9);
    check("post_rst_dres", LS'(last_dres - t0), LS'(7));
    check("post_rst_dres_count", LS'(n_dres - n0), LS'(1));

    // Random traffic.
    for (int k = 0; k < 600; k++)
      tick($urandom_range(0, 99) < 20, $urandom, $urandom_range(0, 99) < 20, $urandom,
           $urandom_range(0, 99) < 15, $urandom, {$urandom, $urandom, $urandom, $urandom});
    idle(25);

    // MEM_LATENCY = 1 instance.
    en_cnt = 0; en_first = -1; b_ires_k = -1;
    @(posedge clk);
    #1;
    b_i_read = 1; b_i_addr = 32'h0000_0ABC; b_mem_rdata = {4{32'h1234_5678}};
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      b_i_read = 0;
      if (b_mem_en) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
      end
      if (b_i_res) begin
        b_ires_k = k;
        check("lat1_data", b_i_res_data, {4{32'h1234_5678}});
        check("lat1_addr", LS'(b_i_res_addr), LS'(32'h0000_0ABC));
      end
    end
    check("lat1_busy_cycles", LS'(en_cnt), LS'(1));
    check("lat1_busy_first", LS'(en_first), LS'(2));
    check("lat1_resp_cycle", LS'(b_ires_k), LS'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
